// File: rtl/tlp2regif_mc_pkg.sv
// Shared definitions for the multi-channel TLP register-access receiver:
// TLP fmt/type codes, FSM encodings and the DW byte-swap helper.
package tlp2regif_mc_pkg;

  localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'b10_00000;
  localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'b11_00000;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_H32,
    RX_P32,
    RX_H64,
    RX_P64
  } rx_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_WAIT,
    O_REL
  } out_state_t;

  // TRN payload bytes arrive little-endian within each big-endian DW
  function automatic logic [31:0] dw_endian_conv(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/tlp2regif_mc_fifo.sv
// Synchronous FIFO with show-ahead read; a push on a full FIFO succeeds
// only when a pop happens in the same cycle.
module regif_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tlp2regif_mc.sv
// Decodes posted MWr32/MWr64 TLPs into per-channel op writes (queued, drained
// over a 4-phase handshake) and per-channel completion-address writes.
module tlp2regif_mc
  import tlp2regif_mc_pkg::*;
#(
  parameter int         BARHIT     = 2,
  parameter int         NUM_CH     = 4,
  parameter logic [5:0] OP_BASE    = 6'h20,
  parameter logic [5:0] CPL_BASE   = 6'h30,
  parameter int         FIFO_DEPTH = 4,
  parameter bit         WRIF       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           trn_rd,
  input  logic [7:0]            trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic [64*NUM_CH-1:0]  cpl_addr,
  output logic [2:0]            acc_ch,
  output logic [31:0]           acc_addr,
  output logic [31:0]           acc_data,
  output logic                  acc_en,
  input  logic                  acc_en_ack,
  output logic                  ovf
);

  localparam logic [5:0] CH_SPAN = 6'(2 * NUM_CH);
  localparam int         FW      = 3 + 32 + 32;

  function automatic logic in_range(input logic [5:0] off);
    return !off[0] && (off < CH_SPAN);
  endfunction

  rx_state_t   rx_reg, rx_next;
  out_state_t  out_reg, out_next;
  logic [31:0] dw0_reg, dw0_next;
  logic [2:0]  ch_reg, ch_next;
  logic        cpl_sel_reg, cpl_sel_next;
  logic        commit;
  logic [31:0] c_dw0, c_dw1;
  logic [5:0]  dec_d, op_off, cpl_off;
  logic        valid;
  logic        push_req, cpl_we;
  logic [63:0] cpl_wdata;
  logic [31:0] op_addr, op_data;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_dout;
  logic        ack_meta_reg, ack_sync_reg;
  logic [2:0]  acc_ch_reg, acc_ch_next;
  logic [31:0] acc_addr_reg, acc_addr_next;
  logic [31:0] acc_data_reg, acc_data_next;
  logic        acc_en_reg, acc_en_next;
  logic        ovf_reg;
  logic        unused_inputs;

  assign valid         = !trn_rsrc_rdy_n;
  assign unused_inputs = ^{trn_rrem_n, trn_rbar_hit_n};
  assign dec_d         = (rx_reg == RX_H64) ? trn_rd[7:2] : trn_rd[39:34];
  assign op_off        = dec_d - OP_BASE;
  assign cpl_off       = dec_d - CPL_BASE;

  always_comb begin
    rx_next      = rx_reg;
    dw0_next     = dw0_reg;
    ch_next      = ch_reg;
    cpl_sel_next = cpl_sel_reg;
    commit       = 1'b0;
    c_dw0        = dw0_reg;
    c_dw1        = trn_rd[63:32];
    case (rx_reg)
      RX_IDLE: begin
        if (valid && !trn_rsof_n && !trn_rbar_hit_n[BARHIT] && trn_rd[41:32] == 10'd2) begin
          if (trn_rd[62:56] == MEM_WR32_FMT_TYPE)      rx_next = RX_H32;
          else if (trn_rd[62:56] == MEM_WR64_FMT_TYPE) rx_next = RX_H64;
        end
      end
      RX_H32, RX_H64: begin
        if (valid) begin
          rx_next = RX_IDLE;
          if (rx_reg == RX_H32) dw0_next = trn_rd[31:0];
          if (trn_reof_n) begin
            if (in_range(op_off)) begin
              rx_next      = (rx_reg == RX_H32) ? RX_P32 : RX_P64;
              ch_next      = op_off[3:1];
              cpl_sel_next = 1'b0;
            end else if (in_range(cpl_off)) begin
              rx_next      = (rx_reg == RX_H32) ? RX_P32 : RX_P64;
              ch_next      = cpl_off[3:1];
              cpl_sel_next = 1'b1;
            end
          end
        end
      end
      RX_P32, RX_P64: begin
        if (valid) begin
          commit  = 1'b1;
          rx_next = RX_IDLE;
          if (rx_reg == RX_P64) begin
            c_dw0 = trn_rd[63:32];
            c_dw1 = trn_rd[31:0];
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign push_req  = commit && !cpl_sel_reg;
  assign cpl_we    = commit && cpl_sel_reg;
  assign cpl_wdata = {dw_endian_conv(c_dw1), dw_endian_conv(c_dw0)};
  assign op_addr   = WRIF ? dw_endian_conv(c_dw1) : dw_endian_conv(c_dw0);
  assign op_data   = WRIF ? dw_endian_conv(c_dw0) : dw_endian_conv(c_dw1);

  regif_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   ({ch_reg, op_addr, op_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    out_next      = out_reg;
    fifo_pop      = 1'b0;
    acc_ch_next   = acc_ch_reg;
    acc_addr_next = acc_addr_reg;
    acc_data_next = acc_data_reg;
    acc_en_next   = acc_en_reg;
    case (out_reg)
      O_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {acc_ch_next, acc_addr_next, acc_data_next} = fifo_dout;
          out_next = O_REQ;
        end
      end
      O_REQ: begin
        acc_en_next = 1'b1;
        out_next    = O_WAIT;
      end
      O_WAIT: begin
        if (ack_sync_reg) begin
          acc_en_next = 1'b0;
          out_next    = O_REL;
        end
      end
      O_REL: begin
        if (!ack_sync_reg) out_next = O_IDLE;
      end
      default: out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_reg       <= RX_IDLE;
      out_reg      <= O_IDLE;
      dw0_reg      <= '0;
      ch_reg       <= '0;
      cpl_sel_reg  <= 1'b0;
      ack_meta_reg <= 1'b0;
      ack_sync_reg <= 1'b0;
      acc_ch_reg   <= '0;
      acc_addr_reg <= '0;
      acc_data_reg <= '0;
      acc_en_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      rx_reg       <= rx_next;
      out_reg      <= out_next;
      dw0_reg      <= dw0_next;
      ch_reg       <= ch_next;
      cpl_sel_reg  <= cpl_sel_next;
      ack_meta_reg <= acc_en_ack;
      ack_sync_reg <= ack_meta_reg;
      acc_ch_reg   <= acc_ch_next;
      acc_addr_reg <= acc_addr_next;
      acc_data_reg <= acc_data_next;
      acc_en_reg   <= acc_en_next;
      ovf_reg      <= ovf_reg | (push_req && fifo_full && !fifo_pop);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cpl
    logic [63:0] cpl_reg;
    always_ff @(posedge clk) begin
      if (rst)                                 cpl_reg <= '0;
      else if (cpl_we && ch_reg == 3'(gi))     cpl_reg <= cpl_wdata;
    end
    assign cpl_addr[64*gi +: 64] = cpl_reg;
  end

  assign acc_ch   = acc_ch_reg;
  assign acc_addr = acc_addr_reg;
  assign acc_data = acc_data_reg;
  assign acc_en   = acc_en_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_tlp2regif_mc.sv
// Self-checking bench for tlp2regif_mc: scoreboard of expected op accesses
// checked on each acc_en rise, plus per-scenario timing/state checks.
module tb_tlp2regif_mc;

  localparam logic [6:0] BAR_HIT = 7'b1111011;
  localparam logic [6:0] FT32    = 7'h40;
  localparam logic [6:0] FT64    = 7'h60;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  trn_rd = '0;
  logic [7:0]   trn_rrem_n = '0;
  logic         trn_rsof_n = 1'b1;
  logic         trn_reof_n = 1'b1;
  logic         trn_rsrc_rdy_n = 1'b1;
  logic [6:0]   trn_rbar_hit_n = 7'h7f;
  logic [255:0] cpl_addr;
  logic [2:0]   acc_ch;
  logic [31:0]  acc_addr;
  logic [31:0]  acc_data;
  logic         acc_en;
  logic         acc_en_ack;
  logic         ovf;

  logic         ack_hold = 1'b0;
  logic         ack_force = 1'b0;
  logic         ack_follow = 1'b0;
  logic         acc_en_prev = 1'b0;
  logic [66:0]  exp_q[$];
  logic [66:0]  mon_exp;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_rise = 0;

  assign acc_en_ack = ack_hold ? ack_force : ack_follow;

  always #5 clk = ~clk;

  tlp2regif_mc dut (
    .clk            (clk),
    .rst            (rst),
    .trn_rd         (trn_rd),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .cpl_addr       (cpl_addr),
    .acc_ch         (acc_ch),
    .acc_addr       (acc_addr),
    .acc_data       (acc_data),
    .acc_en         (acc_en),
    .acc_en_ack     (acc_en_ack),
    .ovf            (ovf)
  );

  // Scoreboard: every acc_en rise must match the oldest expected op write
  always @(posedge clk) begin
    #1;
    ack_follow = acc_en;
    if (acc_en && !acc_en_prev) begin
      n_rise++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_access: got ch=%0d addr=%h data=%h, required no access",
                 acc_ch, acc_addr, acc_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({acc_ch, acc_addr, acc_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL access_order: got ch=%0d addr=%h data=%h, required ch=%0d addr=%h data=%h",
                   acc_ch, acc_addr, acc_data, mon_exp[66:64], mon_exp[63:32], mon_exp[31:0]);
        end else
          $display("access ch=%0d addr=%h data=%h ok", acc_ch, acc_addr, acc_data);
      end
    end
    acc_en_prev = acc_en;
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len);
    return {1'b0, ft, 14'h0, len, 32'h0000_00ff};
  endfunction

  task automatic beat(input logic sof_n, input logic eof_n, input logic [63:0] d, input logic hit);
    trn_rsrc_rdy_n = 1'b0;
    trn_rsof_n     = sof_n;
    trn_reof_n     = eof_n;
    trn_rd         = d;
    trn_rbar_hit_n = hit ? BAR_HIT : 7'h7f;
    @(posedge clk); #1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rd         = 64'hbad0_bad0_bad0_bad0;
  endtask

  task automatic send_mwr32(input logic [5:0] off, input logic [31:0] dw0, input logic [31:0] dw1,
                            input logic [9:0] len, input logic trunc, input logic hit, input logic gap);
    beat(1'b0, 1'b1, hdr(FT32, len), hit);
    if (gap) begin @(posedge clk); #1; end
    if (trunc) beat(1'b1, 1'b0, {24'h0, off, 2'b00, dw0}, hit);
    else begin
      beat(1'b1, 1'b1, {24'h0, off, 2'b00, dw0}, hit);
      if (gap) begin @(posedge clk); #1; end
      beat(1'b1, 1'b0, {dw1, 32'h0}, hit);
    end
  endtask

  task automatic send_mwr64(input logic [5:0] off, input logic [31:0] dw0, input logic [31:0] dw1);
    beat(1'b0, 1'b1, hdr(FT64, 10'd2), 1'b1);
    beat(1'b1, 1'b1, {32'h0, 24'h0, off, 2'b00}, 1'b1);
    beat(1'b1, 1'b0, {dw0, dw1}, 1'b1);
  endtask

  task automatic send_op(input int ch, input logic [31:0] addr, input logic [31:0] data, input logic expect_it);
    send_mwr32(6'h20 + 6'(2 * ch), bswap(addr), bswap(data), 10'd2, 1'b0, 1'b1, 1'b0);
    if (expect_it) exp_q.push_back({3'(ch), addr, data});
  endtask

  task automatic wait_acc_en(input logic level, input string name);
    int k;
    for (k = 0; k < 50 && acc_en !== level; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (acc_en !== level) begin
      n_fail++;
      $display("FAIL %s: acc_en=%b, required %b within 50 cycles", name, acc_en, level);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ack_hold = 1'b0; ack_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    n_checks++;
    if ({cpl_addr, acc_ch, acc_addr, acc_data, acc_en, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cpl=%h ch=%0d addr=%h data=%h en=%b ovf=%b, required all 0",
               cpl_addr, acc_ch, acc_addr, acc_data, acc_en, ovf);
    end else $display("reset outputs ok");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_op_write;
    ack_hold = 1'b1; ack_force = 1'b0;
    exp_q.push_back({3'd1, 32'h1234_5678, 32'hdead_beef});
    send_mwr32(6'h22, 32'h7856_3412, 32'hefbe_adde, 10'd2, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (acc_en !== 1'b0) begin n_fail++; $display("FAIL op_latency_early: acc_en=%b, required 0", acc_en); end
    @(posedge clk); #1;
    n_checks++;
    if (acc_en !== 1'b1) begin n_fail++; $display("FAIL op_latency: acc_en=%b, required 1", acc_en); end
    ack_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (acc_en !== 1'b1 || acc_addr !== 32'h1234_5678 || acc_data !== 32'hdead_beef || acc_ch !== 3'd1) begin
      n_fail++;
      $display("FAIL op_hold: en=%b ch=%0d addr=%h data=%h, required 1/1/12345678/deadbeef",
               acc_en, acc_ch, acc_addr, acc_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (acc_en !== 1'b0) begin n_fail++; $display("FAIL ack_release: acc_en=%b, required 0", acc_en); end
    else $display("op write handshake ok");
    ack_force = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ack_hold = 1'b0;
  endtask

  task automatic test_cpl_write;
    int rises;
    rises = n_rise;
    send_mwr64(6'h36, 32'h0000_0010, 32'h0000_0001);
    n_checks++;
    if (cpl_addr !== {64'h0100_0000_1000_0000, 192'h0}) begin
      n_fail++;
      $display("FAIL cpl_write: cpl_addr=%h, required ch3=0100000010000000 others 0", cpl_addr);
    end else $display("cpl write ch3 ok");
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (n_rise !== rises) begin n_fail++; $display("FAIL cpl_no_access: rises=%0d, required %0d", n_rise, rises); end
  endtask

  task automatic test_back_to_back;
    int k;
    ack_hold = 1'b1; ack_force = 1'b0;
    send_op(2, 32'ha000_0000, 32'h0000_0000, 1'b1);
    wait_acc_en(1'b1, "prime_access");
    for (k = 0; k < 5; k++) begin
      send_op(k % 4, 32'h1000_0000 + 32'(k), 32'hc0de_0000 + 32'(k * 16), k < 4);
      if (k == 3) begin
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: ovf=%b, required 0 with 4 queued", ovf); end
      end
    end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: ovf=%b, required 1", ovf); end
    else $display("fifth write dropped, ovf set");
    ack_hold = 1'b0;
    for (k = 0; k < 300 && (exp_q.size() != 0 || acc_en); k++) begin @(posedge clk); #1; end
    n_checks++;
    if (exp_q.size() != 0 || acc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d accesses outstanding, acc_en=%b, required 0/0", exp_q.size(), acc_en);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (ovf !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b extra=%0d, required 1/0", ovf, exp_q.size());
    end
  endtask

  task automatic test_ignored;
    int rises;
    rises = n_rise;
    send_mwr32(6'h21, 32'h1111_1111, 32'h2222_2222, 10'd2, 1'b0, 1'b1, 1'b0);
    send_mwr32(6'h22, 32'h3333_3333, 32'h4444_4444, 10'd1, 1'b1, 1'b1, 1'b0);
    send_mwr32(6'h22, 32'h5555_5555, 32'h6666_6666, 10'd2, 1'b1, 1'b1, 1'b0);
    send_mwr32(6'h22, 32'h7777_7777, 32'h8888_8888, 10'd2, 1'b0, 1'b0, 1'b0);
    send_mwr32(6'h38, 32'h9999_9999, 32'haaaa_aaaa, 10'd2, 1'b0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (n_rise !== rises || cpl_addr !== '0) begin
      n_fail++;
      $display("FAIL ignored_writes: rises=%0d cpl=%h, required %0d and 0", n_rise, cpl_addr, rises);
    end else $display("ignored writes ok");
    exp_q.push_back({3'd3, 32'hfeed_0003, 32'h0bad_cafe});
    send_mwr32(6'h26, bswap(32'hfeed_0003), bswap(32'h0bad_cafe), 10'd2, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (n_rise !== rises + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_ignored: rises=%0d pending=%0d, required %0d and 0", n_rise, exp_q.size(), rises + 1);
    end
  endtask

  task automatic test_reset_mid;
    int rises;
    send_mwr64(6'h30, 32'h1122_3344, 32'h5566_7788);
    n_checks++;
    if (cpl_addr[63:0] !== 64'h8877_6655_4433_2211) begin
      n_fail++;
      $display("FAIL cpl_ch0: cpl_addr[63:0]=%h, required 8877665544332211", cpl_addr[63:0]);
    end
    ack_hold = 1'b1; ack_force = 1'b0;
    send_op(0, 32'hb000_0000, 32'h1, 1'b1);
    send_op(1, 32'hb000_0001, 32'h2, 1'b0);
    send_op(2, 32'hb000_0002, 32'h3, 1'b0);
    wait_acc_en(1'b1, "mid_access");
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (acc_en !== 1'b0 || ovf !== 1'b0 || cpl_addr !== '0 || acc_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: en=%b ovf=%b cpl=%h addr=%h, required all 0", acc_en, ovf, cpl_addr, acc_addr);
    end else $display("mid-handshake reset ok");
    rst = 1'b0; ack_hold = 1'b0;
    exp_q.delete();
    rises = n_rise;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (n_rise !== rises) begin n_fail++; $display("FAIL fifo_flushed: rises=%0d, required %0d", n_rise, rises); end
  endtask

  initial begin
    test_reset;
    test_op_write;
    test_cpl_write;
    test_reset;
    test_back_to_back;
    test_reset;
    test_ignored;
    test_reset_mid;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
